// File: rtl/dither_output_packer.sv
// Packs quantised pixel groups from the ditherer into words, tags frame/line boundaries,
// and queues them in a small FIFO for the framebuffer writer.
`timescale 1ns/1ps
module dither_output_packer #(
  parameter int unsigned OUTPUT_BITS = 4,
  parameter int unsigned PIXEL_RATE  = 4,
  parameter int unsigned WORD_BITS   = 32,
  parameter int unsigned FIFO_ABITS  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [OUTPUT_BITS*PIXEL_RATE-1:0] pix_in,
  input  logic                              pix_valid,
  input  logic                              hsync,
  input  logic                              vsync,
  output logic [WORD_BITS-1:0]              word_out,
  output logic                              word_valid,
  input  logic                              word_ready,
  output logic                              word_first,
  output logic                              word_last,
  output logic                              overflow,
  input  logic                              clear_overflow
);

  localparam int unsigned GW    = OUTPUT_BITS * PIXEL_RATE;
  localparam int unsigned G     = WORD_BITS / GW;
  localparam int unsigned CntW  = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned Depth = 1 << FIFO_ABITS;

  localparam logic [CntW-1:0]       CntLast = CntW'(G - 1);
  localparam logic [CntW-1:0]       CntOne  = CntW'(1);
  localparam logic [FIFO_ABITS-1:0] PtrOne  = FIFO_ABITS'(1);
  localparam logic [FIFO_ABITS:0]   CntFull = (FIFO_ABITS + 1)'(Depth);
  localparam logic [FIFO_ABITS:0]   FcOne   = (FIFO_ABITS + 1)'(1);

  typedef enum logic [0:0] {StActive, StFlush} state_e;

  state_e               state_q, state_d;
  logic [WORD_BITS-1:0] acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WORD_BITS-1:0] hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 hold_first_q, hold_first_d;
  logic                 first_flag_q, first_flag_d;

  logic                 push;
  logic                 push_last;
  logic [WORD_BITS-1:0] word_new;

  // Packer: at most one FIFO push per cycle given the input timing rules.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    hold_first_d = hold_first_q;
    first_flag_d = first_flag_q;
    state_d      = state_q;
    push         = 1'b0;
    push_last    = 1'b0;
    word_new     = acc_q;

    if (vsync) begin
      acc_d        = '0;
      cnt_d        = '0;
      hold_valid_d = 1'b0;
      first_flag_d = 1'b1;
      state_d      = StActive;
    end else if (state_q == StFlush) begin
      push         = hold_valid_q;
      push_last    = 1'b1;
      hold_valid_d = 1'b0;
      acc_d        = '0;
      cnt_d        = '0;
      state_d      = StActive;
    end else if (hsync) begin
      push         = hold_valid_q;
      push_last    = (cnt_q == '0);
      hold_valid_d = 1'b0;
      if (cnt_q != '0) begin
        // Upper groups of the accumulator are already zero, giving the padding.
        hold_d       = acc_q;
        hold_first_d = first_flag_q;
        hold_valid_d = 1'b1;
        first_flag_d = 1'b0;
        acc_d        = '0;
        cnt_d        = '0;
        state_d      = StFlush;
      end
    end else if (pix_valid) begin
      word_new                = acc_q;
      word_new[cnt_q*GW +: GW] = pix_in;
      if (cnt_q == CntLast) begin
        push         = hold_valid_q;
        push_last    = 1'b0;
        hold_d       = word_new;
        hold_first_d = first_flag_q;
        hold_valid_d = 1'b1;
        first_flag_d = 1'b0;
        acc_d        = '0;
        cnt_d        = '0;
      end else begin
        acc_d = word_new;
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StActive;
      acc_q        <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_first_q <= 1'b0;
      first_flag_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      hold_first_q <= hold_first_d;
      first_flag_q <= first_flag_d;
    end
  end

  // FIFO entries carry {first, last, word}.
  logic [WORD_BITS+1:0]  mem_q [Depth];
  logic [FIFO_ABITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ABITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_ABITS:0]   fcount_q, fcount_d;
  logic                  overflow_q, overflow_d;
  logic                  fifo_full;
  logic                  pop;
  logic                  wr_en;
  logic                  drop;
  logic [WORD_BITS+1:0]  head;

  always_comb begin
    fifo_full  = (fcount_q == CntFull);
    word_valid = (fcount_q != '0);
    pop        = word_valid && word_ready;
    wr_en      = push && (!fifo_full || pop);
    drop       = push && fifo_full && !pop;

    wr_ptr_d = wr_en ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    fcount_d = fcount_q;
    if (wr_en && !pop) begin
      fcount_d = fcount_q + FcOne;
    end else if (!wr_en && pop) begin
      fcount_d = fcount_q - FcOne;
    end

    // A drop in the same cycle as a clear wins.
    overflow_d = overflow_q;
    if (clear_overflow) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end

    head       = mem_q[rd_ptr_q];
    word_out   = word_valid ? head[WORD_BITS-1:0] : '0;
    word_first = word_valid && head[WORD_BITS+1];
    word_last  = word_valid && head[WORD_BITS];
    overflow   = overflow_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {hold_first_q && !push_last ? hold_first_q : hold_first_q,
                          push_last, hold_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcount_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcount_q   <= fcount_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_dither_output_packer.sv
// Self-checking bench for dither_output_packer: directed table, corner sequences and a
// randomized run against a line/frame level reference model.
`timescale 1ns/1ps
module tb_dither_output_packer;

  localparam int G = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] pix_in;
  logic        pix_valid, hsync, vsync, word_ready, clear_overflow;
  logic [31:0] word_out;
  logic        word_valid, word_first, word_last, overflow;

  logic [3:0]  pix_in1;
  logic        pix_valid1, hsync1, vsync1, word_ready1, clear_overflow1;
  logic [31:0] word_out1;
  logic        word_valid1, word_first1, word_last1, overflow1;

  dither_output_packer dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .hsync(hsync),
    .vsync(vsync), .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .word_first(word_first), .word_last(word_last), .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  dither_output_packer #(.OUTPUT_BITS(1), .PIXEL_RATE(4), .WORD_BITS(32), .FIFO_ABITS(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in1), .pix_valid(pix_valid1), .hsync(hsync1),
    .vsync(vsync1), .word_out(word_out1), .word_valid(word_valid1), .word_ready(word_ready1),
    .word_first(word_first1), .word_last(word_last1), .overflow(overflow1),
    .clear_overflow(clear_overflow1)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [33:0] got[$];
  logic [33:0] got1[$];
  logic [33:0] exp_q[$];
  logic        pv = 1'b0, pr = 1'b0;
  logic [31:0] pw = '0;
  bit          rnd_ready = 1'b0;

  always @(negedge clk) begin
    if (rst_n && word_valid && pv && !pr) check("stable", word_out, pw);
    if (rst_n && word_valid && word_ready) got.push_back({word_first, word_last, word_out});
    if (rst_n && word_valid1 && word_ready1) got1.push_back({word_first1, word_last1, word_out1});
    pv = rst_n && word_valid;
    pr = word_ready;
    pw = word_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) word_ready = ($urandom_range(0, 3) != 0);
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic grp(input logic [15:0] g);
    pix_in = g; pix_valid = 1'b1; tick(); pix_valid = 1'b0;
  endtask
  task automatic hs();
    hsync = 1'b1; tick(); hsync = 1'b0; idle(2);
  endtask
  task automatic vs();
    vsync = 1'b1; tick(); vsync = 1'b0;
  endtask

  // Reference model: words of a line are formed when the line ends (hsync); a vsync
  // loses the partial word plus the most recent complete word of the current line.
  logic [15:0] line[$];
  bit          mfirst;

  function automatic void emit(input int nwords, input bit last_final);
    for (int w = 0; w < nwords; w++) begin
      logic [31:0] word = '0;
      for (int k = 0; k < G; k++)
        if (w * G + k < line.size()) word[k*16 +: 16] = line[w*G + k];
      exp_q.push_back({(w == 0) && mfirst, last_final && (w == nwords - 1), word});
    end
    if (nwords > 0) mfirst = 1'b0;
  endfunction
  function automatic void model_hs();
    emit((line.size() + G - 1) / G, 1'b1);
    line.delete();
  endfunction
  function automatic void model_vs();
    int c = line.size() / G;
    emit((c > 0) ? c - 1 : 0, 1'b0);
    line.delete();
    mfirst = 1'b1;
  endfunction

  typedef struct packed {
    logic              vs;
    int unsigned       n;
    logic [3:0][15:0]  g;
    int unsigned       nw;
    logic [1:0][31:0]  w;
    logic [1:0]        f;
    logic [1:0]        l;
    logic              lat_v;
    logic [31:0]       lat_w;
  } vec_t;

  vec_t vecs[5];

  initial begin
    pix_in = '0; pix_valid = 0; hsync = 0; vsync = 0; word_ready = 1; clear_overflow = 0;
    pix_in1 = '0; pix_valid1 = 0; hsync1 = 0; vsync1 = 0; word_ready1 = 1; clear_overflow1 = 0;

    foreach (vecs[i]) vecs[i] = '0;
    vecs[0].n = 4; vecs[0].g = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
    vecs[0].nw = 2; vecs[0].w = {32'hDEF09ABC, 32'h56781234}; vecs[0].f = 2'b01;
    vecs[0].l = 2'b10; vecs[0].lat_v = 1; vecs[0].lat_w = 32'hDEF09ABC;
    vecs[1].n = 3; vecs[1].g = {16'h0, 16'h3333, 16'h2222, 16'h1111};
    vecs[1].nw = 2; vecs[1].w = {32'h00003333, 32'h22221111}; vecs[1].f = 2'b00;
    vecs[1].l = 2'b10; vecs[1].lat_v = 1; vecs[1].lat_w = 32'h22221111;
    vecs[2].n = 2; vecs[2].g = {16'h0, 16'h0, 16'hBBBB, 16'hAAAA};
    vecs[2].nw = 1; vecs[2].w = {32'h0, 32'hBBBBAAAA}; vecs[2].l = 2'b01;
    vecs[2].lat_v = 1; vecs[2].lat_w = 32'hBBBBAAAA;
    vecs[3].vs = 1; vecs[3].n = 1; vecs[3].g = {16'h0, 16'h0, 16'h0, 16'hCDEF};
    vecs[3].nw = 1; vecs[3].w = {32'h0, 32'h0000CDEF}; vecs[3].f = 2'b01; vecs[3].l = 2'b01;
    vecs[4].n = 0; vecs[4].nw = 0;

    #12;
    check("rst_valid", word_valid, 0);
    check("rst_out", word_out, 0);
    check("rst_first", word_first, 0);
    check("rst_last", word_last, 0);
    check("rst_ovf", overflow, 0);
    check("rst_valid1", word_valid1, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 5; i++) begin
      got.delete();
      if (vecs[i].vs) vs();
      for (int j = 0; j < int'(vecs[i].n); j++) grp(vecs[i].g[j]);
      hsync = 1'b1; tick(); hsync = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_lat_valid", i), word_valid, vecs[i].lat_v);
      if (vecs[i].lat_v) check($sformatf("v%0d_lat_word", i), word_out, vecs[i].lat_w);
      idle(5);
      check($sformatf("v%0d_count", i), got.size(), vecs[i].nw);
      for (int k = 0; k < int'(vecs[i].nw) && k < got.size(); k++)
        check($sformatf("v%0d_w%0d", i, k), got[k],
              {vecs[i].f[k], vecs[i].l[k], vecs[i].w[k]});
    end

    // One-bit pixels: 8 groups per word
    for (int i = 0; i < 8; i++) begin
      pix_in1 = 4'hF; pix_valid1 = 1'b1; tick(); pix_valid1 = 1'b0;
    end
    hsync1 = 1'b1; tick(); hsync1 = 1'b0; idle(4);
    check("obit_count", got1.size(), 1);
    if (got1.size() > 0) check("obit_word", got1[0], {1'b1, 1'b1, 32'hFFFFFFFF});

    // Randomized lines against the model
    rnd_ready = 1'b1;
    vs();
    line.delete(); mfirst = 1'b0; model_vs();
    got.delete(); exp_q.delete();
    for (int l = 0; l < 40; l++) begin
      int n = $urandom_range(0, 9);
      bit mid = ($urandom_range(0, 7) == 0);
      int cut = mid ? $urandom_range(0, n) : n;
      for (int i = 0; i < cut; i++) begin
        logic [15:0] g = 16'($urandom);
        grp(g);
        line.push_back(g);
        if ($urandom_range(0, 2) == 0) idle(1);
      end
      if (mid) begin
        vs(); model_vs();
      end else begin
        hs(); model_hs();
        if ($urandom_range(0, 9) == 0) begin
          vs(); model_vs();
        end
      end
    end
    rnd_ready = 1'b0; word_ready = 1'b1;
    idle(40);
    check("rand_count", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("rand_w%0d", i), got[i], exp_q[i]);
    check("rand_ovf", overflow, 0);

    // Overflow: 17 words pushed into a 16-deep FIFO with ready low
    vs();
    word_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 34; i++) grp(16'h4000 + 16'(i));
    hs();
    check("ovf_set", overflow, 1);
    check("ovf_valid", word_valid, 1);
    check("ovf_head", word_out, 32'h40014000);
    word_ready = 1'b1;
    idle(20);
    check("ovf_drain_count", got.size(), 16);
    for (int k = 0; k < 16 && k < got.size(); k++)
      check($sformatf("ovf_w%0d", k), got[k],
            {k == 0, 1'b0, 16'h4000 + 16'(2*k+1), 16'h4000 + 16'(2*k)});
    check("ovf_sticky", overflow, 1);
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    check("ovf_clear", overflow, 0);

    // vsync mid-line: queued FIFO words survive, pending groups are lost
    word_ready = 1'b0;
    got.delete();
    grp(16'hA000); grp(16'hA001); hs();
    grp(16'hB000); grp(16'hB001); grp(16'hB002);
    vs();
    grp(16'hC000); grp(16'hC001); hs();
    word_ready = 1'b1;
    idle(6);
    check("vs_count", got.size(), 2);
    if (got.size() > 0) check("vs_w0", got[0], {1'b0, 1'b1, 32'hA001A000});
    if (got.size() > 1) check("vs_w1", got[1], {1'b1, 1'b1, 32'hC001C000});

    // Asynchronous reset mid-burst
    word_ready = 1'b0;
    for (int i = 0; i < 34; i++) grp(16'h6000 + 16'(i));
    hs();
    check("ar_pre_ovf", overflow, 1);
    grp(16'h7000); grp(16'h7001); grp(16'h7002);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("ar_valid", word_valid, 0);
    check("ar_ovf", overflow, 0);
    check("ar_out", word_out, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    word_ready = 1'b1;
    got.delete();
    tick();
    grp(16'h5000); grp(16'h5001); grp(16'h5002); grp(16'h5003);
    hs(); idle(4);
    check("ar_count", got.size(), 2);
    if (got.size() > 0) check("ar_w0", got[0], {1'b1, 1'b0, 32'h50015000});
    if (got.size() > 1) check("ar_w1", got[1], {1'b0, 1'b1, 32'h50035002});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dither_output_packer.md
Name: dither_output_packer

Overview:
- Sits downstream of the error diffusion ditherer and consumes its unbuffered quantised pixel stream (OUTPUT_BITS per pixel, PIXEL_RATE pixels per cycle).
- Packs pixel groups into WORD_BITS words and marks the first word of each frame and the last word of each line.
- Buffers words in a small FIFO and presents them to the framebuffer writer over a valid/ready handshake.

Parameters:
- OUTPUT_BITS, 4, bits per pixel. Legal values: 1 or 4.
- PIXEL_RATE, 4, pixels per input cycle.
- WORD_BITS, 32, output word width. Must be a multiple of OUTPUT_BITS*PIXEL_RATE. G = WORD_BITS/(OUTPUT_BITS*PIXEL_RATE) groups per word.
- FIFO_ABITS, 4, log2 of FIFO depth (16 words).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_in  in  OUTPUT_BITS*PIXEL_RATE  quantised pixel group. Leftmost pixel is in the MSBs, matching the ditherer output order.
- pix_valid  in  1  pix_in valid this cycle.
- hsync  in  1  line boundary pulse.
- vsync  in  1  frame boundary pulse.
- word_out  out  WORD_BITS  packed word.
- word_valid  out  1  word_out valid.
- word_ready  in  1  downstream accepts the word when word_valid&&word_ready.
- word_first  out  1  word_out is the first word of a frame.
- word_last  out  1  word_out holds the final pixel group of a line.
- overflow  out  1  sticky; set when a word is dropped because the FIFO is full.
- clear_overflow  in  1  synchronous clear of overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - word_valid=0, word_out=0, word_first=0, word_last=0, overflow=0.
  - FIFO empty, accumulator empty, hold register empty, first_flag=1, FSM=ACTIVE.
  - Deasserting reset mid-line restarts cleanly; no partial word is emitted.
- Packing:
  - Group k of a word (k=0..G-1, in arrival order) occupies word bits [k*gw +: gw], where gw=OUTPUT_BITS*PIXEL_RATE. Groups are not reordered.
  - A group counter wraps at G.
  - On the G-th group the word completes. The completed word moves to a one-word hold register tagged with first=first_flag, and first_flag is then cleared.
  - If the hold register is already occupied at that moment, the held word is pushed to the FIFO with last=0 in the same cycle.
- FSM states: ACTIVE, FLUSH.
  - ACTIVE + hsync: push the held word (if any) to the FIFO with last = (accumulator empty).
    - If the accumulator is partial, zero-pad its upper groups, move it to the hold register with last=1, and go to FLUSH.
    - Otherwise stay in ACTIVE.
  - FLUSH: push the hold register to the FIFO, clear the counter, return to ACTIVE. Takes exactly one cycle.
  - hsync with no pixels since the previous hsync pushes nothing.
- vsync (highest priority, same cycle as anything else):
  - Discard the accumulator and hold register without pushing.
  - Set first_flag=1 and force FSM=ACTIVE.
  - The FIFO keeps its contents.
- Input timing constraints (not checked):
  - pix_valid and hsync are never high in the same cycle.
  - pix_valid is low for at least 2 cycles after hsync.
- FIFO:
  - Synchronous, registered outputs. A word pushed at cycle N is visible on word_out/word_valid at cycle N+1 if the FIFO was empty.
  - word_first and word_last travel with their word.
  - Simultaneous push and pop on a full FIFO is legal and loses nothing.
  - A push to a full FIFO without a pop drops the word and sets overflow.
  - clear_overflow clears overflow. If clear_overflow and a drop happen in the same cycle, overflow stays set.
- word_out is stable while word_valid=1 and word_ready=0.

Test Plan:
- Defaults, one line of 4 groups (0x1234, 0x5678, 0x9ABC, 0xDEF0), word_ready=1, then hsync:
  - Words 0x56781234 (first=1,last=0) and 0xDEF09ABC (first=0,last=1).
  - Second word visible 1 cycle after hsync.
- Line of 3 groups (0x1111, 0x2222, 0x3333) then hsync:
  - 0x22221111 (last=0), then 0x00003333 (last=1) after the FLUSH cycle.
- OUTPUT_BITS=1, PIXEL_RATE=4, WORD_BITS=32 (G=8), 8 groups of 0xF then hsync:
  - One word 0xFFFFFFFF with last=1.
- word_ready=0, 17 full words pushed:
  - The first 16 are retained and the 17th is dropped; overflow=1.
  - Raise ready: 16 words drain in order.
  - Pulse clear_overflow: overflow=0.
- vsync after 3 groups mid-line:
  - No word emitted for those groups.
  - The next completed word has word_first=1.
  - FIFO contents queued before vsync are still delivered.
- Assert rst_n=0 asynchronously mid-burst, between clock edges:
  - word_valid and overflow drop immediately.
  - After release, the next line produces words starting at group 0 with first=1.
